// File: rtl/lsq_ctrl_pkg.sv
// rtl/lsq_ctrl_pkg.sv - shared sizes, index types and lane prefix-count helper for the STQ controller
//
// Purpose : geometry of the STQ/LDQ and dispatch bundle, index typedefs, and
//           prefix_count(), the exclusive popcount of mask bits below lane k.
// Ports   : none (package)
package lsq_ctrl_pkg;

  localparam int DISPATCH_WIDTH = 4;
  localparam int COMMIT_WIDTH   = 4;
  localparam int STQ_DEPTH      = 16;
  localparam int STQ_INDEX      = 4;
  localparam int LDQ_DEPTH      = 16;
  localparam int LDQ_INDEX      = 4;
  localparam int CMT_W          = $clog2(COMMIT_WIDTH) + 1;
  localparam int PC_W           = $clog2(DISPATCH_WIDTH + 1);

  typedef logic [STQ_INDEX-1:0] stqIdx_t;
  typedef logic [LDQ_INDEX-1:0] ldqIdx_t;
  typedef logic [STQ_INDEX:0]   stqCnt_t;

  // Number of set bits of mask strictly below position k.
  function automatic int prefix_count(input logic [31:0] mask, input int k);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < k && mask[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/lane_prefix_count.sv
// rtl/lane_prefix_count.sv - exclusive per-lane prefix popcount of a lane mask
//
// Purpose : prefix[k] = number of set mask bits in lanes below k.
// Ports   : mask   in  WIDTH       lane mask
//           prefix out WIDTH*CW    packed per-lane exclusive counts
module lane_prefix_count
  import lsq_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic [WIDTH-1:0]    mask,
  output logic [WIDTH*CW-1:0] prefix
);

  logic [31:0] mask_ext;

  always_comb begin
    mask_ext = '0;
    mask_ext[WIDTH-1:0] = mask;
    prefix = '0;
    for (int k = 0; k < WIDTH; k++) begin
      prefix[k*CW +: CW] = CW'(prefix_count(mask_ext, k));
    end
  end

endmodule

// File: rtl/stq_followingld_ctrl.sv
// rtl/stq_followingld_ctrl.sv - STQ dispatch/commit sequencer for the following-load RAM
//
// Purpose : allocates STQ slots for stores in a dispatch bundle, writes each
//           store's following-load LDQ index into the RAM (registered write
//           ports), tracks head/tail/count and exposes the head store's index.
// Ports   : clk, reset (async active-low)
//           dispValid_i/dispReady_o, laneValid_i, isStore_i, isLoad_i, ldqTail_i : dispatch
//           stqId_o                           : per-lane allocated STQ slot (combinational)
//           ramWe_o, ramAddrWr_o, ramDataWr_o : registered RAM write ports
//           ramAddrRd_o, ramDataRd_i          : asynchronous RAM read at head
//           commitCnt_i, flush_i              : retirement and recovery
//           headValid_o, headFollowingLd_o, stqCount_o, error_o : status
module stq_followingld_ctrl
  import lsq_ctrl_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              dispValid_i,
  output logic                              dispReady_o,
  input  logic [DISPATCH_WIDTH-1:0]         laneValid_i,
  input  logic [DISPATCH_WIDTH-1:0]         isStore_i,
  input  logic [DISPATCH_WIDTH-1:0]         isLoad_i,
  input  logic [LDQ_INDEX-1:0]              ldqTail_i,
  output logic [DISPATCH_WIDTH*STQ_INDEX-1:0] stqId_o,
  output logic [DISPATCH_WIDTH-1:0]         ramWe_o,
  output logic [DISPATCH_WIDTH*STQ_INDEX-1:0] ramAddrWr_o,
  output logic [DISPATCH_WIDTH*LDQ_INDEX-1:0] ramDataWr_o,
  output logic [STQ_INDEX-1:0]              ramAddrRd_o,
  input  logic [LDQ_INDEX-1:0]              ramDataRd_i,
  input  logic [CMT_W-1:0]                  commitCnt_i,
  input  logic                              flush_i,
  output logic                              headValid_o,
  output logic [LDQ_INDEX-1:0]              headFollowingLd_o,
  output logic [STQ_INDEX:0]                stqCount_o,
  output logic                              error_o
);

  stqIdx_t head, tail;
  stqCnt_t count;

  logic [DISPATCH_WIDTH-1:0]        st_mask, ld_mask;
  logic [DISPATCH_WIDTH*PC_W-1:0]   st_pre, ld_pre;
  logic [DISPATCH_WIDTH*LDQ_INDEX-1:0] lane_data;
  logic    fire;
  logic    underflow;
  stqCnt_t n_st, n_cm, commit_ext;

  assign st_mask = laneValid_i & isStore_i;
  assign ld_mask = laneValid_i & isLoad_i;

  lane_prefix_count #(.WIDTH(DISPATCH_WIDTH), .CW(PC_W)) u_st_prefix (
    .mask   (st_mask),
    .prefix (st_pre)
  );

  lane_prefix_count #(.WIDTH(DISPATCH_WIDTH), .CW(PC_W)) u_ld_prefix (
    .mask   (ld_mask),
    .prefix (ld_pre)
  );

  // Ready looks only at the registered count, so a full queue that commits
  // this cycle still reports not-ready until the next cycle.
  assign dispReady_o = (count <= stqCnt_t'(STQ_DEPTH - DISPATCH_WIDTH));
  assign fire        = dispValid_i & dispReady_o & ~flush_i;

  // Index arithmetic truncates to the index width, which is the wrap mod depth.
  always_comb begin
    stqId_o   = '0;
    lane_data = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      stqId_o[k*STQ_INDEX +: STQ_INDEX]   = tail + stqIdx_t'(st_pre[k*PC_W +: PC_W]);
      lane_data[k*LDQ_INDEX +: LDQ_INDEX] = ldqTail_i + ldqIdx_t'(ld_pre[k*PC_W +: PC_W]);
    end
  end

  assign n_st       = fire ? stqCnt_t'(prefix_count(32'(st_mask), DISPATCH_WIDTH)) : '0;
  assign commit_ext = stqCnt_t'(commitCnt_i);
  assign underflow  = commit_ext > count;
  assign n_cm       = underflow ? count : commit_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      ramWe_o     <= '0;
      ramAddrWr_o <= '0;
      ramDataWr_o <= '0;
      error_o     <= 1'b0;
    end else if (flush_i) begin
      // The write registered last cycle was already presented this cycle;
      // only the dropped bundle is suppressed.
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ramWe_o <= '0;
    end else begin
      tail        <= tail + stqIdx_t'(n_st);
      head        <= head + stqIdx_t'(n_cm);
      count       <= count + n_st - n_cm;
      ramWe_o     <= fire ? st_mask : '0;
      ramAddrWr_o <= stqId_o;
      ramDataWr_o <= lane_data;
      if (underflow) error_o <= 1'b1;
    end
  end

  // Read-after-write: a store dispatched into an empty queue raises
  // headValid_o one cycle after dispatch, but its RAM write lands on that
  // same edge, so headFollowingLd_o is only stable one cycle later.
  // Consumers must qualify head data with headValid_o delayed by one cycle.
  assign ramAddrRd_o       = head;
  assign headFollowingLd_o = ramDataRd_i;
  assign headValid_o       = (count != '0);
  assign stqCount_o        = count;

endmodule

// File: tb/tb_stq_followingld_ctrl.sv
// tb/tb_stq_followingld_ctrl.sv - directed self-checking bench for stq_followingld_ctrl
module tb_stq_followingld_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        dispValid_i;
  logic        dispReady_o;
  logic [3:0]  laneValid_i, isStore_i, isLoad_i;
  logic [3:0]  ldqTail_i;
  logic [15:0] stqId_o;
  logic [3:0]  ramWe_o;
  logic [15:0] ramAddrWr_o;
  logic [15:0] ramDataWr_o;
  logic [3:0]  ramAddrRd_o;
  logic [3:0]  ramDataRd_i;
  logic [2:0]  commitCnt_i;
  logic        flush_i;
  logic        headValid_o;
  logic [3:0]  headFollowingLd_o;
  logic [4:0]  stqCount_o;
  logic        error_o;

  int errors = 0;
  int checks = 0;

  logic [3:0] mem [16];

  stq_followingld_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .dispValid_i       (dispValid_i),
    .dispReady_o       (dispReady_o),
    .laneValid_i       (laneValid_i),
    .isStore_i         (isStore_i),
    .isLoad_i          (isLoad_i),
    .ldqTail_i         (ldqTail_i),
    .stqId_o           (stqId_o),
    .ramWe_o           (ramWe_o),
    .ramAddrWr_o       (ramAddrWr_o),
    .ramDataWr_o       (ramDataWr_o),
    .ramAddrRd_o       (ramAddrRd_o),
    .ramDataRd_i       (ramDataRd_i),
    .commitCnt_i       (commitCnt_i),
    .flush_i           (flush_i),
    .headValid_o       (headValid_o),
    .headFollowingLd_o (headFollowingLd_o),
    .stqCount_o        (stqCount_o),
    .error_o           (error_o)
  );

  always #5 clk = ~clk;

  // Following-load RAM: registered writes, asynchronous read.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (ramWe_o[k]) mem[ramAddrWr_o[k*4 +: 4]] <= ramDataWr_o[k*4 +: 4];
  end
  assign ramDataRd_i = mem[ramAddrRd_o];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    dispValid_i = 1'b0;
    laneValid_i = 4'b0;
    isStore_i   = 4'b0;
    isLoad_i    = 4'b0;
    ldqTail_i   = 4'd0;
    commitCnt_i = 3'd0;
    flush_i     = 1'b0;
  endtask

  task automatic bundle(input logic [3:0] lv, input logic [3:0] st,
                        input logic [3:0] ld, input logic [3:0] lt);
    dispValid_i = 1'b1;
    laneValid_i = lv;
    isStore_i   = st;
    isLoad_i    = ld;
    ldqTail_i   = lt;
    #1;
  endtask

  task automatic commit(input int n);
    commitCnt_i = 3'(n);
    tick();
    commitCnt_i = 3'd0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'd0;
    reset = 1'b0;
    idle();
    repeat (2) @(negedge clk);

    check("rst_ready", dispReady_o, 1);
    check("rst_hvalid", headValid_o, 0);
    check("rst_we", ramWe_o, 0);
    check("rst_count", stqCount_o, 0);
    check("rst_err", error_o, 0);
    check("rst_rdaddr", ramAddrRd_o, 0);
    reset = 1'b1;
    @(negedge clk);

    // {St,Ld,St,Ld} with ldqTail 5
    bundle(4'hF, 4'b0101, 4'b1010, 4'd5);
    check("t1_id0", stqId_o[3:0], 0);
    check("t1_id2", stqId_o[11:8], 1);
    tick(); idle();
    check("t1_we", ramWe_o, 4'b0101);
    check("t1_addr0", ramAddrWr_o[3:0], 0);
    check("t1_addr2", ramAddrWr_o[11:8], 1);
    check("t1_data0", ramDataWr_o[3:0], 5);
    check("t1_data2", ramDataWr_o[11:8], 6);
    check("t1_count", stqCount_o, 2);
    tick();
    check("t1_hvalid", headValid_o, 1);
    check("t1_headld", headFollowingLd_o, 5);
    check("t1_we_off", ramWe_o, 0);

    // Move tail to 14, then a wrapping 3-store bundle
    commit(2);
    check("t2_count0", stqCount_o, 0);
    check("t2_head2", ramAddrRd_o, 2);
    repeat (3) begin bundle(4'hF, 4'hF, 4'h0, 4'd0); tick(); end
    idle();
    repeat (3) commit(4);
    check("t2_head14", ramAddrRd_o, 14);
    check("t2_empty", stqCount_o, 0);
    bundle(4'b0111, 4'b0111, 4'b0000, 4'd9);
    check("t2_id0", stqId_o[3:0], 14);
    check("t2_id1", stqId_o[7:4], 15);
    check("t2_id2", stqId_o[11:8], 0);
    tick(); idle();
    check("t2_addr0", ramAddrWr_o[3:0], 14);
    check("t2_addr1", ramAddrWr_o[7:4], 15);
    check("t2_addr2", ramAddrWr_o[11:8], 0);
    check("t2_data2", ramDataWr_o[11:8], 9);
    check("t2_count3", stqCount_o, 3);
    tick();
    check("t2_headld", headFollowingLd_o, 9);
    commit(3);
    check("t2_head1", ramAddrRd_o, 1);
    check("t2_count_end", stqCount_o, 0);
    bundle(4'h0, 4'h0, 4'h0, 4'd0);
    check("t2_tail1", stqId_o[3:0], 1);
    idle();

    // Fill to 13, full-with-commit keeps ready low that cycle
    repeat (3) begin bundle(4'hF, 4'hF, 4'h0, 4'd0); tick(); end
    idle();
    check("t3_count12", stqCount_o, 12);
    check("t3_ready12", dispReady_o, 1);
    bundle(4'b0001, 4'b0001, 4'b0000, 4'd0); tick(); idle();
    check("t3_count13", stqCount_o, 13);
    check("t3_ready13", dispReady_o, 0);
    bundle(4'hF, 4'hF, 4'h0, 4'd0);
    commitCnt_i = 3'd1;
    #1;
    check("t3_ready_cm", dispReady_o, 0);
    tick(); idle();
    check("t3_count_after", stqCount_o, 12);
    check("t3_ready_next", dispReady_o, 1);
    check("t3_no_we", ramWe_o, 0);

    // Commit underflow
    commit(4); commit(4); commit(2);
    check("t4_count2", stqCount_o, 2);
    check("t4_head12", ramAddrRd_o, 12);
    commit(3);
    check("t4_count0", stqCount_o, 0);
    check("t4_head14", ramAddrRd_o, 14);
    check("t4_err", error_o, 1);
    tick();
    check("t4_err_sticky", error_o, 1);

    // Flush with a valid 4-store bundle at count 7
    bundle(4'hF, 4'hF, 4'h0, 4'd0); tick();
    bundle(4'b0111, 4'b0111, 4'b0000, 4'd0); tick();
    check("t5_count7", stqCount_o, 7);
    bundle(4'hF, 4'hF, 4'h0, 4'd0);
    flush_i = 1'b1;
    #1;
    check("t5_we_delivered", ramWe_o, 4'b0111);
    tick(); idle();
    #1;
    check("t5_we_off", ramWe_o, 0);
    check("t5_count", stqCount_o, 0);
    check("t5_head", ramAddrRd_o, 0);
    check("t5_tail", stqId_o[3:0], 0);
    check("t5_hvalid", headValid_o, 0);
    check("t5_err_kept", error_o, 1);

    // Reset while a write is registered
    @(negedge clk);
    bundle(4'b0011, 4'b0011, 4'b0000, 4'd3); tick(); idle();
    check("t6_we_pending", ramWe_o, 4'b0011);
    reset = 1'b0;
    #1;
    check("t6_we", ramWe_o, 0);
    check("t6_count", stqCount_o, 0);
    check("t6_head", ramAddrRd_o, 0);
    check("t6_tail", stqId_o[3:0], 0);
    check("t6_err", error_o, 0);
    check("t6_ready", dispReady_o, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
